// File: rtl/tcdm_filter_rule_ctrl.sv
// TCDM address-filter configuration controller: APB shadow/active rule tables,
// drain-then-commit sequencing of the monitored port, and first-violation capture.
module tcdm_filter_rule_ctrl #(
    parameter int N_RULES         = 8,
    parameter int APB_ADDR_WIDTH  = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic                      pwrite,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic                      mon_req_i,
    input  logic                      mon_gnt_i,
    input  logic                      mon_r_valid_i,
    input  logic [31:0]               mon_add_i,
    input  logic                      mon_wen_i,
    input  logic                      error_i,
    output logic                      hold_o,
    output logic                      filter_en_o,
    output logic [N_RULES*32-1:0]     RULES_o,
    output logic                      irq_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [31:0] SHADOW_WORD = 32'h10;  // word index of byte offset 0x040
    localparam logic [31:0] ACTIVE_WORD = 32'h20;  // word index of byte offset 0x080
    localparam logic [31:0] NR          = 32'(N_RULES);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

    state_t           state;
    logic [31:0]      shadow_rules [N_RULES];
    logic [31:0]      active_rules [N_RULES];
    logic             shadow_en, active_en, irq_en;
    logic             err_valid, cnt_err, err_wen;
    logic [31:0]      err_addr;
    logic [7:0]       err_count;
    logic [CNT_W-1:0] outstanding;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]      word_addr;
    logic [IDX_W-1:0] rule_idx;
    logic aligned, sel_ctrl, sel_status, sel_err_addr, sel_err_info, sel_shadow, sel_active, sel_valid;
    logic cfg_write, access, wr_en, commit_req, clr_err_valid, clr_cnt_err, inc, dec;

    assign word_addr    = 32'(paddr[APB_ADDR_WIDTH-1:2]);
    assign rule_idx     = word_addr[IDX_W-1:0];
    assign aligned      = (paddr[1:0] == 2'b00);
    assign sel_ctrl     = aligned && (word_addr == 32'd0);
    assign sel_status   = aligned && (word_addr == 32'd1);
    assign sel_err_addr = aligned && (word_addr == 32'd2);
    assign sel_err_info = aligned && (word_addr == 32'd3);
    assign sel_shadow   = aligned && (word_addr >= SHADOW_WORD) && (word_addr < SHADOW_WORD + NR);
    assign sel_active   = aligned && (word_addr >= ACTIVE_WORD) && (word_addr < ACTIVE_WORD + NR);
    assign sel_valid    = sel_ctrl | sel_status | sel_err_addr | sel_err_info | sel_shadow | sel_active;

    // Configuration writes stall while a commit is in flight so they can never race the copy.
    assign cfg_write     = psel & pwrite & (sel_ctrl | sel_shadow);
    assign pready        = ~(cfg_write & (state != IDLE));
    assign access        = psel & penable & pready;
    assign wr_en         = access & pwrite;
    assign pslverr       = psel & penable & ~sel_valid;
    assign commit_req    = wr_en & sel_ctrl & pwdata[1];
    assign clr_err_valid = wr_en & sel_status & pwdata[1];
    assign clr_cnt_err   = wr_en & sel_status & pwdata[2];
    assign inc           = mon_req_i & mon_gnt_i;
    assign dec           = mon_r_valid_i;

    always_comb begin
        prdata = '0;
        if (psel && penable && !pwrite) begin
            if (sel_ctrl)          prdata = {29'd0, irq_en, 1'b0, shadow_en};
            else if (sel_status)   prdata = {16'd0, err_count, 5'd0, cnt_err, err_valid, state != IDLE};
            else if (sel_err_addr) prdata = err_addr;
            else if (sel_err_info) prdata = {31'd0, err_wen};
            else if (sel_shadow)   prdata = shadow_rules[rule_idx];
            else if (sel_active)   prdata = active_rules[rule_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            cnt_err     <= 1'b0;
        end else begin
            if (clr_cnt_err) cnt_err <= 1'b0;
            if (inc && !dec) begin
                if (outstanding == CNT_MAX) cnt_err <= 1'b1;
                else                        outstanding <= outstanding + CNT_W'(1);
            end else if (dec && !inc) begin
                if (outstanding == '0) cnt_err <= 1'b1;
                else                   outstanding <= outstanding - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_o    <= 1'b0;
            shadow_en <= 1'b0;
            active_en <= 1'b0;
            irq_en    <= 1'b0;
            for (int i = 0; i < N_RULES; i++) begin
                shadow_rules[i] <= '0;
                active_rules[i] <= '0;
            end
        end else begin
            if (wr_en && sel_ctrl) begin
                shadow_en <= pwdata[0];
                irq_en    <= pwdata[2];
            end
            if (wr_en && sel_shadow) shadow_rules[rule_idx] <= pwdata;
            case (state)
                IDLE: if (commit_req) begin
                    state  <= DRAIN;
                    hold_o <= 1'b1;
                end
                DRAIN: if (outstanding == '0) state <= COMMIT;
                COMMIT: begin
                    for (int i = 0; i < N_RULES; i++) active_rules[i] <= shadow_rules[i];
                    active_en <= shadow_en;
                    state     <= IDLE;
                    hold_o    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    hold_o <= 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with a new error re-arms capture on that same error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_wen   <= 1'b0;
            err_count <= '0;
            irq_o     <= 1'b0;
        end else begin
            irq_o <= err_valid & irq_en;
            if (clr_err_valid) err_valid <= 1'b0;
            if (error_i) begin
                err_count <= sat_inc8(err_count);
                if (!err_valid || clr_err_valid) begin
                    err_valid <= 1'b1;
                    err_addr  <= mon_add_i;
                    err_wen   <= mon_wen_i;
                end
            end
        end
    end

    assign filter_en_o = active_en;
    for (genvar g = 0; g < N_RULES; g++) begin : g_rules
        assign RULES_o[g*32 +: 32] = active_rules[g];
    end
endmodule

// File: tb/tb_tcdm_filter_rule_ctrl.sv
// Self-checking bench for tcdm_filter_rule_ctrl: APB register map, commit/drain
// sequencing, violation capture and outstanding-counter corner cases.
module tb_tcdm_filter_rule_ctrl;
    localparam int N_RULES = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [11:0]             paddr;
    logic [31:0]             pwdata;
    logic                    pwrite, psel, penable;
    logic [31:0]             prdata;
    logic                    pready, pslverr;
    logic                    mon_req_i, mon_gnt_i, mon_r_valid_i;
    logic [31:0]             mon_add_i;
    logic                    mon_wen_i, error_i;
    logic                    hold_o, filter_en_o, irq_o;
    logic [N_RULES*32-1:0]   RULES_o;

    tcdm_filter_rule_ctrl #(.N_RULES(N_RULES), .APB_ADDR_WIDTH(12), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mon_req_i(mon_req_i), .mon_gnt_i(mon_gnt_i), .mon_r_valid_i(mon_r_valid_i),
        .mon_add_i(mon_add_i), .mon_wen_i(mon_wen_i), .error_i(error_i), .hold_o(hold_o),
        .filter_en_o(filter_en_o), .RULES_o(RULES_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t exp_q[$];
    vec_t reset_tbl[12];
    vec_t map_tbl[9];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_acc = 0;
    int   e0       = 0;

    function automatic logic [31:0] rule(input int i);
        return RULES_o[i*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int waits);
        waits = 0;
        rd    = '0;
        err   = 1'b0;
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        forever begin
            @(negedge clk);
            if (pready) begin
                rd  = prdata;
                err = pslverr;
                @(posedge clk); #1;
                last_acc = cyc;
                break;
            end
            waits++;
            if (waits > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL apb_timeout: addr 0x%03h stalled %0d cycles, required completion", a, waits);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [31:0] rd;
        logic        err;
        int          waits;
        vec_t        e;
        exp_q.push_back(v);
        apb_xfer(v.addr, v.write, v.wdata, rd, err, waits);
        e = exp_q.pop_front();
        if (!e.write) check({name, " rdata"}, rd, e.exp_rdata);
        check({name, " pslverr"}, 32'(err), 32'(e.exp_err));
        check({name, " waits"}, 32'(waits), 32'd0);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string name);
        run_vec('{addr: a, write: 1'b0, wdata: 32'd0, exp_rdata: exp, exp_err: 1'b0}, name);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input string name);
        run_vec('{addr: a, write: 1'b1, wdata: d, exp_rdata: 32'd0, exp_err: 1'b0}, name);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;

        for (int i = 0; i < 8; i++)
            reset_tbl[i] = '{addr: 12'(12'h080 + 4*i), write: 1'b0, wdata: 32'd0, exp_rdata: 32'd0, exp_err: 1'b0};
        for (int i = 0; i < 4; i++)
            reset_tbl[8+i] = '{addr: 12'(4*i), write: 1'b0, wdata: 32'd0, exp_rdata: 32'd0, exp_err: 1'b0};

        map_tbl[0] = '{addr: 12'h100, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'd0,          exp_err: 1'b1};
        map_tbl[1] = '{addr: 12'h100, write: 1'b1, wdata: 32'hFFFFFFFF, exp_rdata: 32'd0,          exp_err: 1'b1};
        map_tbl[2] = '{addr: 12'h0A0, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'd0,          exp_err: 1'b1};
        map_tbl[3] = '{addr: 12'h080, write: 1'b1, wdata: 32'hDEADBEEF, exp_rdata: 32'd0,          exp_err: 1'b0};
        map_tbl[4] = '{addr: 12'h008, write: 1'b1, wdata: 32'hFFFFFFFF, exp_rdata: 32'd0,          exp_err: 1'b0};
        map_tbl[5] = '{addr: 12'h080, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'h00004003,   exp_err: 1'b0};
        map_tbl[6] = '{addr: 12'h008, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'h22220000,   exp_err: 1'b0};
        map_tbl[7] = '{addr: 12'h000, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'h00000005,   exp_err: 1'b0};
        map_tbl[8] = '{addr: 12'h040, write: 1'b0, wdata: 32'd0,        exp_rdata: 32'h00004003,   exp_err: 1'b0};

        rst = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        mon_req_i = 1'b0; mon_gnt_i = 1'b0; mon_r_valid_i = 1'b0; mon_add_i = '0;
        mon_wen_i = 1'b0; error_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset hold_o", 32'(hold_o), 32'd0);
        check("reset filter_en_o", 32'(filter_en_o), 32'd0);
        check("reset irq_o", 32'(irq_o), 32'd0);
        check("reset RULES_o nonzero", 32'(|RULES_o), 32'd0);
        check("reset pready", 32'(pready), 32'd1);
        check("reset prdata", prdata, 32'd0);
        for (int i = 0; i < 12; i++) run_vec(reset_tbl[i], $sformatf("reset_read[%0d]", i));

        // Commit with an idle port: hold for two cycles, active update after E2
        wr(12'h040, 32'h00004003, "shadow0 write");
        rd_chk(12'h040, 32'h00004003, "shadow0 readback");
        rd_chk(12'h080, 32'h0, "active0 before commit");
        wr(12'h000, 32'h3, "ctrl commit idle");
        check("idle commit hold after E0", 32'(hold_o), 32'd1);
        check("idle commit filter_en after E0", 32'(filter_en_o), 32'd0);
        tick(1);
        check("idle commit hold after E1", 32'(hold_o), 32'd1);
        check("idle commit rule0 after E1", rule(0), 32'd0);
        tick(1);
        check("idle commit hold after E2", 32'(hold_o), 32'd0);
        check("idle commit rule0 after E2", rule(0), 32'h00004003);
        check("idle commit filter_en after E2", 32'(filter_en_o), 32'd1);
        rd_chk(12'h004, 32'h0, "status after idle commit");
        rd_chk(12'h000, 32'h1, "ctrl after idle commit");

        // Commit with two reads outstanding; a shadow write during DRAIN must wait
        wr(12'h044, 32'h12345678, "shadow1 write");
        mon_req_i = 1'b1; mon_gnt_i = 1'b1;
        tick(2);
        mon_req_i = 1'b0; mon_gnt_i = 1'b0;
        wr(12'h000, 32'h3, "ctrl commit busy");
        e0 = last_acc;
        check("busy commit hold after E0", 32'(hold_o), 32'd1);
        fork
            begin
                logic [31:0] rd2;
                logic        err2;
                int          waits2;
                apb_xfer(12'h048, 1'b1, 32'hCAFEF00D, rd2, err2, waits2);
                check("stalled write accept edge", 32'(last_acc - e0), 32'd7);
                check("stalled write waits", 32'(waits2), 32'd5);
            end
            begin
                tick(2);
                check("drain pready", 32'(pready), 32'd0);
                mon_r_valid_i = 1'b1;
                tick(2);
                mon_r_valid_i = 1'b0;
                tick(1);
                check("drain hold before update", 32'(hold_o), 32'd1);
                check("drain rule1 before update", rule(1), 32'd0);
                check("commit-cycle pready", 32'(pready), 32'd0);
                tick(1);
                check("drain hold after update", 32'(hold_o), 32'd0);
                check("drain rule1 after update", rule(1), 32'h12345678);
                check("drain rule2 excluded", rule(2), 32'd0);
            end
        join
        rd_chk(12'h048, 32'hCAFEF00D, "shadow2 after stall");
        rd_chk(12'h084, 32'h12345678, "active1 after drain");
        rd_chk(12'h088, 32'h0, "active2 after drain");

        // Violation capture and interrupt
        wr(12'h000, 32'h5, "ctrl irq_en");
        error_i = 1'b1; mon_add_i = 32'h1C010000; mon_wen_i = 1'b0;
        tick(1);
        check("irq one edge after first error", 32'(irq_o), 32'd0);
        mon_add_i = 32'h1A000040; mon_wen_i = 1'b1;
        tick(1);
        error_i = 1'b0;
        check("irq after errors", 32'(irq_o), 32'd1);
        rd_chk(12'h008, 32'h1C010000, "err_addr first");
        rd_chk(12'h00C, 32'h0, "err_info first");
        rd_chk(12'h004, 32'h00000202, "status two errors");
        wr(12'h004, 32'h2, "w1c err_valid");
        check("irq at clear edge", 32'(irq_o), 32'd1);
        tick(1);
        check("irq after clear", 32'(irq_o), 32'd0);
        rd_chk(12'h004, 32'h00000200, "status after clear");
        error_i = 1'b1; mon_add_i = 32'h11110000; mon_wen_i = 1'b0;
        tick(1);
        error_i = 1'b0;
        fork
            wr(12'h004, 32'h2, "w1c with new error");
            begin
                tick(1);
                error_i = 1'b1; mon_add_i = 32'h22220000; mon_wen_i = 1'b1;
                tick(1);
                error_i = 1'b0;
            end
        join
        rd_chk(12'h008, 32'h22220000, "err_addr set wins");
        rd_chk(12'h00C, 32'h1, "err_info set wins");
        rd_chk(12'h004, 32'h00000402, "status set wins");
        error_i = 1'b1; mon_add_i = 32'h33330000;
        tick(260);
        error_i = 1'b0;
        rd_chk(12'h004, 32'h0000FF02, "err_count saturated");
        rd_chk(12'h008, 32'h22220000, "err_addr held");
        check("irq still set", 32'(irq_o), 32'd1);

        // Invalid offsets and writes to read-only registers
        for (int i = 0; i < 9; i++) run_vec(map_tbl[i], $sformatf("map[%0d]", i));

        // Outstanding counter saturation and underflow
        mon_req_i = 1'b1; mon_gnt_i = 1'b1;
        tick(5);
        mon_req_i = 1'b0; mon_gnt_i = 1'b0;
        rd_chk(12'h004, 32'h0000FF06, "cnt_err on overflow");
        wr(12'h004, 32'h4, "w1c cnt_err");
        rd_chk(12'h004, 32'h0000FF02, "cnt_err cleared");
        mon_r_valid_i = 1'b1;
        tick(4);
        mon_r_valid_i = 1'b0;
        rd_chk(12'h004, 32'h0000FF02, "drain of saturated count");
        mon_r_valid_i = 1'b1;
        tick(1);
        mon_r_valid_i = 1'b0;
        rd_chk(12'h004, 32'h0000FF06, "cnt_err on underflow");
        wr(12'h000, 32'h7, "commit after underflow");
        check("underflow commit hold E0", 32'(hold_o), 32'd1);
        tick(2);
        check("underflow commit hold E2", 32'(hold_o), 32'd0);

        // Reset while draining
        mon_req_i = 1'b1; mon_gnt_i = 1'b1;
        tick(1);
        mon_req_i = 1'b0; mon_gnt_i = 1'b0;
        wr(12'h04C, 32'hAAAA5555, "shadow3 write");
        wr(12'h000, 32'h3, "commit before reset");
        tick(1);
        check("hold before reset", 32'(hold_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset mid-drain hold", 32'(hold_o), 32'd0);
        check("reset mid-drain rules", 32'(|RULES_o), 32'd0);
        check("reset mid-drain filter_en", 32'(filter_en_o), 32'd0);
        check("reset mid-drain irq", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        rd_chk(12'h004, 32'h0, "status after reset");
        rd_chk(12'h04C, 32'h0, "shadow3 after reset");
        rd_chk(12'h040, 32'h0, "shadow0 after reset");
        rd_chk(12'h000, 32'h0, "ctrl after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tcdm_filter_rule_ctrl.md
# tcdm_filter_rule_ctrl

Configuration and sequencing controller for the TCDM address filter. It holds shadow and active copies of the filter rule table behind an APB slave. It commits shadow to active atomically, only after the filtered port has drained its outstanding transactions. It also captures the first filter violation and raises an interrupt.

## Interface
- N_RULES, 8, number of 32-bit rules; format {A[1:0], BASE[14:0], SIZE[13:0], S}
- APB_ADDR_WIDTH, 12, APB address width
- MAX_OUTSTANDING, 4, maximum in-flight transactions tracked on the monitored port
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- paddr  in  APB_ADDR_WIDTH  APB address (byte address, word aligned)
- pwdata  in  32  APB write data
- pwrite, psel, penable  in  1 each  APB control
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- mon_req_i, mon_gnt_i, mon_r_valid_i  in  1 each  upstream (master-side) handshake of the filtered port
- mon_add_i  in  32  upstream address
- mon_wen_i  in  1  upstream wen
- error_i  in  1  filter error strobe
- hold_o  out  1  registered; integration ANDs ~hold_o into the upstream request
- filter_en_o  out  1  active filter enable
- RULES_o  out  N_RULES x 32  active rule table
- irq_o  out  1  registered violation interrupt

## Operation
- Register map (byte offsets):
  - 0x000 CTRL: bit0 filter_en (shadow), bit1 commit (write-1, reads 0), bit2 irq_en.
  - 0x004 STATUS: bit0 commit_pending (RO), bit1 err_valid (W1C), bit2 cnt_err (W1C), [15:8] err_count (RO, saturates at 255).
  - 0x008 ERR_ADDR (RO).
  - 0x00C ERR_INFO: bit0 wen (RO).
  - 0x040+4*i: shadow rule i (RW).
  - 0x080+4*i: active rule i (RO).
- Other offsets: pslverr=1, write ignored, prdata=0.
- Writes to RO fields are ignored without error.
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on mon_req_i&mon_gnt_i; -1 on mon_r_valid_i; both in the same cycle leaves it unchanged.
  - Increment at MAX_OUTSTANDING saturates and sets cnt_err.
  - Decrement at 0 holds 0 and sets cnt_err.
- FSM states IDLE, DRAIN, COMMIT:
  - IDLE -> DRAIN on an accepted CTRL write with bit1=1.
  - DRAIN -> COMMIT when counter==0.
  - COMMIT -> IDLE unconditionally. In the COMMIT cycle, shadow rules and shadow filter_en are copied to active.
  - hold_o=1 in DRAIN and COMMIT. commit_pending=1 in DRAIN and COMMIT.
- APB writes to CTRL or shadow rules while not IDLE: pready=0 (wait states) until the FSM returns to IDLE, then accepted.
  - Consequence: a commit during a commit is serialized, never lost.
- All reads, and writes to STATUS, complete with zero wait states in any state.
- Violation capture:
  - On error_i with err_valid=0: capture mon_add_i into ERR_ADDR, mon_wen_i into ERR_INFO, set err_valid.
  - On error_i with err_valid=1: capture registers unchanged.
  - err_count increments on every error_i, saturating at 255. Cleared only by reset.
  - W1C of err_valid in the same cycle as a new error_i: set wins, new values captured.
- irq_o = registered (err_valid & irq_en).

## Timing
- Reset values: every register 0 and FSM IDLE. Therefore RULES_o=0, filter_en_o=0 (pass-through), hold_o=0, irq_o=0, prdata=0.
- pready is 1 whenever no stall applies. pslverr is valid only in the access phase.
- APB write takes effect at the clock edge ending the access phase (psel&penable&pready). Read data is combinational in the access phase.
- Commit write accepted at edge E0:
  - hold_o=1 after E0.
  - Idle port: counter 0 at E1 -> COMMIT; RULES_o/filter_en_o update and hold_o=0 after E2.
  - Non-idle port: active update follows the last r_valid by 2 edges.
- A request granted in the cycle hold_o rises is still counted and drained.
- Capture registers and error counter update at the edge of the error_i cycle. irq_o follows one edge later.
- Reset mid-DRAIN: FSM returns to IDLE, hold_o=0, active and shadow tables revert to 0.

## Test plan
- Reset, read 0x080..0x09C and STATUS -> all 0, filter_en_o=0, hold_o=0, pready=1.
- Write shadow rule 0=0x0000_4003, CTRL=0x3 with port idle -> hold_o high 2 cycles, RULES_o[0]=0x0000_4003 and filter_en_o=1 after E2, STATUS.bit0=0.
- Two reads granted without r_valid, then commit -> hold_o stays high; active update 2 edges after the second r_valid; shadow write issued during DRAIN sees pready=0 until IDLE.
- error_i at 0x1C01_0000 (read), then at 0x1A00_0040 (write), irq_en=1 -> ERR_ADDR=0x1C01_0000, ERR_INFO=0, err_count=2, irq_o=1; W1C bit1 -> irq_o=0 one cycle later.
- MAX_OUTSTANDING+1 grants without r_valid -> counter holds 4, cnt_err=1; r_valid with counter 0 -> stays 0.
- APB access to 0x100 -> pslverr=1, prdata=0, no state change.
